// File: rtl/hex_scan_pkg.sv
// Shared types and helpers for the two-digit seven-segment scan driver.
// Logical segment/digit values are active-high; the helpers map them to pin levels.
package hex_scan_pkg;

  typedef enum logic [1:0] {
    SHOW0 = 2'd0,
    GAP0  = 2'd1,
    SHOW1 = 2'd2,
    GAP1  = 2'd3
  } state_t;

  localparam int SEG_W   = 7;
  localparam int DIG0_LO = 0;
  localparam int DIG1_LO = 7;

  // Dwell counter holds (cycles - 1), so it needs $clog2 of the longest dwell.
  function automatic int cnt_width(input int show_cycles, input int gap_cycles);
    int longest;
    longest = (show_cycles > gap_cycles) ? show_cycles : gap_cycles;
    return ($clog2(longest) > 0) ? $clog2(longest) : 1;
  endfunction

  function automatic logic [SEG_W-1:0] seg_phys(input logic [SEG_W-1:0] lit,
                                                input logic active_low);
    return active_low ? ~lit : lit;
  endfunction

  function automatic logic [1:0] dig_phys(input logic [1:0] on, input logic active_low);
    return active_low ? ~on : on;
  endfunction

  function automatic logic [SEG_W-1:0] seg_off(input logic active_low);
    return seg_phys('0, active_low);
  endfunction

  function automatic logic [1:0] dig_off(input logic active_low);
    return dig_phys(2'b00, active_low);
  endfunction

endpackage

// File: rtl/hex_scan_timer.sv
// Loadable down-counter; tc is high while the count sits at zero.
// Loading (dwell - 1) gives a terminal count after exactly dwell cycles.
module hex_scan_timer #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (count_reg != '0) begin
      count_reg <= count_reg - W'(1);
    end
  end

  assign tc = (count_reg == '0);

endmodule

// File: rtl/hex_scan_driver.sv
// Two-digit multiplexed seven-segment driver with blanking gaps and a
// once-per-frame snapshot of the 14-bit segment word.
module hex_scan_driver
  import hex_scan_pkg::*;
#(
  parameter int CLK_DIV        = 50000,
  parameter int BLANK_CYCLES   = 500,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int DIG_ACTIVE_LOW = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [13:0] seg_in,
  output logic [6:0]  seg_out,
  output logic [1:0]  dig_en,
  output logic        frame_tick
);

  localparam int CNT_W = cnt_width(CLK_DIV, BLANK_CYCLES);
  localparam logic [CNT_W-1:0] SHOW_LOAD = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = (BLANK_CYCLES > 0) ? CNT_W'(BLANK_CYCLES - 1) : '0;
  localparam logic SEG_AL = (SEG_ACTIVE_LOW != 0);
  localparam logic DIG_AL = (DIG_ACTIVE_LOW != 0);
  localparam logic [SEG_W-1:0] SEG_OFF = seg_off(SEG_AL);
  localparam logic [1:0] DIG_OFF = dig_off(DIG_AL);
  localparam logic [1:0] DIG0_ON = dig_phys(2'b01, DIG_AL);
  localparam logic [1:0] DIG1_ON = dig_phys(2'b10, DIG_AL);

  state_t            state_reg;
  state_t            state_next;
  logic              armed_reg;
  logic [13:0]       snapshot_reg;
  logic [SEG_W-1:0]  seg_out_reg;
  logic [1:0]        dig_en_reg;
  logic              frame_tick_reg;

  logic              forced_idle;
  logic              timer_load;
  logic [CNT_W-1:0]  timer_val;
  logic              timer_tc;

  hex_scan_timer #(
    .W (CNT_W)
  ) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (timer_load),
    .load_val (timer_val),
    .tc       (timer_tc)
  );

  // armed_reg lags enable by one edge, so both reset release and re-enable
  // spend one edge reloading the GAP1 dwell before counting it out.
  assign forced_idle = !enable || !armed_reg;

  always_comb begin
    state_next = state_reg;
    if (forced_idle) begin
      state_next = GAP1;
    end else if (timer_tc) begin
      unique case (state_reg)
        SHOW0:   state_next = (BLANK_CYCLES > 0) ? GAP0 : SHOW1;
        GAP0:    state_next = SHOW1;
        SHOW1:   state_next = (BLANK_CYCLES > 0) ? GAP1 : SHOW0;
        default: state_next = SHOW0;
      endcase
    end
    timer_load = forced_idle || timer_tc;
    timer_val  = (state_next == SHOW0 || state_next == SHOW1) ? SHOW_LOAD : GAP_LOAD;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= GAP1;
      armed_reg      <= 1'b0;
      snapshot_reg   <= '0;
      seg_out_reg    <= SEG_OFF;
      dig_en_reg     <= DIG_OFF;
      frame_tick_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      armed_reg      <= enable;
      frame_tick_reg <= 1'b0;
      unique case (state_next)
        SHOW0: begin
          if (state_reg != SHOW0) begin
            snapshot_reg   <= seg_in;
            seg_out_reg    <= seg_phys(seg_in[DIG0_LO +: SEG_W], SEG_AL);
            dig_en_reg     <= DIG0_ON;
            frame_tick_reg <= 1'b1;
          end
        end
        SHOW1: begin
          seg_out_reg <= seg_phys(snapshot_reg[DIG1_LO +: SEG_W], SEG_AL);
          dig_en_reg  <= DIG1_ON;
        end
        default: begin
          seg_out_reg <= SEG_OFF;
          dig_en_reg  <= DIG_OFF;
        end
      endcase
    end
  end

  assign seg_out    = seg_out_reg;
  assign dig_en     = dig_en_reg;
  assign frame_tick = frame_tick_reg;

endmodule
